// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller and its decoder.
// Contents: segment patterns SEG_0..SEG_9 and SEG_BLANK ({a,b,c,d,e,f,g}, bit6 = a, 1 = lit),
// and the scan state type.
// Optional feature macro used by seg7_scan_ctrl: SEG7_LEADING_ZERO_BLANK_EN.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   typedef enum logic {
      BLANK,
      DRIVE
   } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder; values 10-15 decode to all segments dark.
// Ports:
//   digit_i  4-bit digit value
//   seg_o    segments {a,b,c,d,e,f,g}, bit6 = a, 1 = lit
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-select 7-segment digits sharing one
// seg/dp bus. A per-digit value/dp buffer is written through a valid/ready port; each digit is
// visited as a BLANK dwell (all dark, anti-ghosting) followed by a DRIVE dwell.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (suppress leading zeros, digit 0 excepted).
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   scan_en             1 = scanning, 0 = display dark and sequencer parked in BLANK
//   wr_valid/wr_ready   write handshake; wr_idx/wr_val/wr_dp give target digit, value, dp
//   seg, dp, an         registered segment bus, decimal point, one-hot digit select
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned IDX_W        = $clog2(NUM_DIGITS),
   parameter int unsigned DWELL_CYCLES = 12000,
   parameter int unsigned BLANK_CYCLES = 120
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  scan_en,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [3:0]            wr_val,
   input  logic                  wr_dp,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] an
);

   localparam int unsigned MaxCycles = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES
                                                                    : BLANK_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   scan_state_e           state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
   logic [3:0]            buf_val_q [NUM_DIGITS];
   logic [3:0]            buf_val_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] buf_dp_q, buf_dp_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  wr_ready_q;

   logic [3:0]            cur_val;
   logic [6:0]            cur_seg;
   logic                  suppress;

   assign cur_val = buf_val_q[scan_idx_q];

   seg7_decode u_decode (
      .digit_i (cur_val),
      .seg_o   (cur_seg)
   );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // A zero is leading when no higher digit holds a visible 1-9.
   always_comb begin
      suppress = (cur_val == 4'd0) && (scan_idx_q != '0);
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if ((IDX_W'(j) > scan_idx_q) && (buf_val_q[j] >= 4'd1) && (buf_val_q[j] <= 4'd9)) begin
            suppress = 1'b0;
         end
      end
   end
`else
   assign suppress = 1'b0;
`endif

   // Buffer write port; out-of-range indices match no entry and are dropped.
   always_comb begin
      buf_val_d = buf_val_q;
      buf_dp_d  = buf_dp_q;
      if (wr_valid && wr_ready_q) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
               buf_val_d[i] = wr_val;
               buf_dp_d[i]  = wr_dp;
            end
         end
      end
   end

   // Scan sequencer. Outputs are loaded from the old buffer contents on the DRIVE-entry edge,
   // so a same-edge write appears on the next visit.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CntW'(1);
      scan_idx_d = scan_idx_q;
      an_d       = an_q;
      seg_d      = seg_q;
      dp_d       = dp_q;
      if (!scan_en) begin
         state_d = BLANK;
         cnt_d   = '0;
         an_d    = '0;
         seg_d   = SEG_BLANK;
         dp_d    = 1'b0;
      end else begin
         unique case (state_q)
            BLANK: begin
               if (cnt_q == CntW'(BLANK_CYCLES - 1)) begin
                  state_d = DRIVE;
                  cnt_d   = '0;
                  an_d    = NUM_DIGITS'(1) << scan_idx_q;
                  seg_d   = suppress ? SEG_BLANK : cur_seg;
                  dp_d    = buf_dp_q[scan_idx_q];
               end
            end
            DRIVE: begin
               if (cnt_q == CntW'(DWELL_CYCLES - 1)) begin
                  state_d    = BLANK;
                  cnt_d      = '0;
                  an_d       = '0;
                  seg_d      = SEG_BLANK;
                  dp_d       = 1'b0;
                  scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                                      : scan_idx_q + IDX_W'(1);
               end
            end
            default: begin
               state_d = BLANK;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BLANK;
         cnt_q      <= '0;
         scan_idx_q <= '0;
         buf_val_q  <= '{default: '0};
         buf_dp_q   <= '0;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b0;
         an_q       <= '0;
         wr_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         scan_idx_q <= scan_idx_d;
         buf_val_q  <= buf_val_d;
         buf_dp_q   <= buf_dp_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
         wr_ready_q <= 1'b1;
      end
   end

   assign seg      = seg_q;
   assign dp       = dp_q;
   assign an       = an_q;
   assign wr_ready = wr_ready_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (NUM_DIGITS=4, DWELL_CYCLES=8, BLANK_CYCLES=2).
// The reference model describes the display as a repeating period of BLANK+DWELL cycles per
// digit, counted from the last time scanning (re)started; it pushes the expected outputs after
// each edge into a queue that a separate monitor pops and compares on the falling edge.
// Honours SEG7_LEADING_ZERO_BLANK_EN the same way as the design.
module tb_seg7_scan_ctrl;

   localparam int N = 4;
   localparam int D = 8;
   localparam int B = 2;
   localparam int P = B + D;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         scan_en;
   logic         wr_valid;
   logic         wr_ready;
   logic [1:0]   wr_idx;
   logic [3:0]   wr_val;
   logic         wr_dp;
   logic [6:0]   seg;
   logic         dp;
   logic [N-1:0] an;

   int checks = 0;
   int errors = 0;

   seg7_scan_ctrl #(
      .NUM_DIGITS   (N),
      .IDX_W        (2),
      .DWELL_CYCLES (D),
      .BLANK_CYCLES (B)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .scan_en  (scan_en),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_idx   (wr_idx),
      .wr_val   (wr_val),
      .wr_dp    (wr_dp),
      .seg      (seg),
      .dp       (dp),
      .an       (an)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] v);
      case (v)
         4'd0: return 7'b1111110;
         4'd1: return 7'b0110000;
         4'd2: return 7'b1101101;
         4'd3: return 7'b1111001;
         4'd4: return 7'b0110011;
         4'd5: return 7'b1011011;
         4'd6: return 7'b1011111;
         4'd7: return 7'b1110000;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [N-1:0] an;
      logic [6:0]   seg;
      logic         dp;
      logic         rdy;
   } exp_t;

   exp_t         exp_q[$];
   int           e_cnt;      // edges since scanning (re)started
   int           start_dig;  // digit at which the current run began
   logic [3:0]   mbuf [N];
   logic [N-1:0] mdp;
   logic         mrdy;
   logic [N-1:0] m_an;
   logic [6:0]   m_seg;
   logic         m_dp;

   function automatic bit leading_zero(input int d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (d == 0 || mbuf[d] != 4'd0) return 1'b0;
      for (int j = d + 1; j < N; j++) if (mbuf[j] >= 1 && mbuf[j] <= 9) return 1'b0;
      return 1'b1;
`else
      return (d < 0);
`endif
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            e_cnt = 0; start_dig = 0; mdp = '0; mrdy = 1'b0;
            for (int i = 0; i < N; i++) mbuf[i] = 4'd0;
            m_an = '0; m_seg = '0; m_dp = 1'b0;
            exp_q.delete();
         end else begin
            bit fire;
            fire = wr_valid && mrdy;
            if (!scan_en) begin
               start_dig = (start_dig + e_cnt / P) % N;
               e_cnt = 0;
               m_an = '0; m_seg = '0; m_dp = 1'b0;
            end else begin
               int p, d;
               e_cnt++;
               p = e_cnt % P;
               d = (start_dig + e_cnt / P) % N;
               if (p == B) begin
                  m_an  = N'(1) << d;
                  m_seg = leading_zero(d) ? 7'd0 : ref_seg(mbuf[d]);
                  m_dp  = mdp[d];
               end else if (p < B) begin
                  m_an = '0; m_seg = '0; m_dp = 1'b0;
               end
            end
            if (fire && int'(wr_idx) < N) begin
               mbuf[wr_idx] = wr_val;
               mdp[wr_idx]  = wr_dp;
            end
            mrdy = 1'b1;
            exp_q.push_back('{an: m_an, seg: m_seg, dp: m_dp, rdy: mrdy});
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_an", 32'(an), 0);
            chk("rst_seg", 32'(seg), 0);
            chk("rst_dp", 32'(dp), 0);
            chk("rst_rdy", 32'(wr_ready), 0);
         end else if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("an", 32'(an), 32'(x.an));
            chk("seg", 32'(seg), 32'(x.seg));
            chk("dp", 32'(dp), 32'(x.dp));
            chk("wr_ready", 32'(wr_ready), 32'(x.rdy));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic write(input int idx, input logic [3:0] val, input logic dpv);
      @(negedge clk);
      wr_valid = 1'b1; wr_idx = 2'(idx); wr_val = val; wr_dp = dpv;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Waits (at a falling edge) until the model shows digit dig being driven.
   task automatic wait_drive(input int dig, input string name);
      bit found = 1'b0;
      for (int k = 0; k < 4 * N * P && !found; k++) begin
         @(negedge clk);
         if (m_an == N'(1) << dig) found = 1'b1;
      end
      if (!found) chk({name, "_timeout"}, 1, 0);
   endtask

   initial begin
      rst_n = 1'b0; scan_en = 1'b1; wr_valid = 1'b0; wr_idx = '0; wr_val = '0; wr_dp = 1'b0;
      cycles(3);
      #2 rst_n = 1'b1;
      #1 chk("rdy_before_edge", 32'(wr_ready), 0);
      @(posedge clk); #1 chk("rdy_after_edge", 32'(wr_ready), 1);

      // Basic pattern 1,2,3,4
      write(0, 4'd1, 1'b0);
      write(1, 4'd2, 1'b0);
      write(2, 4'd3, 1'b0);
      write(3, 4'd4, 1'b0);
      cycles(2 * N * P);
      wait_drive(3, "drive3");
      chk("digit3_seg", 32'(seg), 32'(7'b0110011));

      // Blank value with dp
      write(1, 4'd11, 1'b1);
      wait_drive(1, "drive1");
      chk("blank_dp_seg", 32'(seg), 0);
      chk("blank_dp_dp", 32'(dp), 1);

      // Write idx2 exactly on its DRIVE-entry edge
      begin
         bit found = 1'b0;
         for (int k = 0; k < 4 * N * P && !found; k++) begin
            int ne;
            @(negedge clk);
            ne = e_cnt + 1;
            if (ne % P == B && (start_dig + ne / P) % N == 2) found = 1'b1;
         end
         if (!found) chk("entry_timeout", 1, 0);
         wr_valid = 1'b1; wr_idx = 2'd2; wr_val = 4'd7; wr_dp = 1'b0;
         @(posedge clk); #1 chk("snapshot_old", 32'(seg), 32'(7'b1111001));
         @(negedge clk); wr_valid = 1'b0;
         wait_drive(3, "after_entry");
         wait_drive(2, "next_visit");
         chk("snapshot_new", 32'(seg), 32'(7'b1110000));
      end

      // scan_en low mid-DRIVE of idx1
      wait_drive(1, "pre_off");
      cycles(3);
      scan_en = 1'b0;
      @(posedge clk); #1 chk("scan_off_an", 32'(an), 0);
      cycles(4);
      scan_en = 1'b1;
      @(posedge clk); #1 chk("reen_dark", 32'(an), 0);
      @(posedge clk); #1 chk("reen_an", 32'(an), 32'(4'b0010));

      // Asynchronous reset mid-DRIVE
      wait_drive(0, "pre_rst");
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      chk("async_an", 32'(an), 0);
      chk("async_seg", 32'(seg), 0);
      chk("async_rdy", 32'(wr_ready), 0);
      cycles(2);
      #2 rst_n = 1'b1;
      wait_drive(0, "post_rst");
      chk("post_rst_seg0", 32'(seg), 32'(7'b1111110));
      cycles(N * P);

      // Randomized traffic
      for (int k = 0; k < 800; k++) begin
         @(negedge clk);
         wr_valid = ($urandom % 3) == 0;
         wr_idx   = 2'($urandom % N);
         wr_val   = (($urandom % 3) == 0) ? 4'd0 : 4'($urandom % 16);
         wr_dp    = 1'($urandom % 2);
         scan_en  = ($urandom % 40) != 0;
      end
      @(negedge clk);
      wr_valid = 1'b0; scan_en = 1'b1;

      // Leading-zero pattern {0,0,3,0} (idx3..0)
      write(3, 4'd0, 1'b0);
      write(2, 4'd0, 1'b0);
      write(1, 4'd3, 1'b0);
      write(0, 4'd0, 1'b0);
      cycles(2 * N * P);
      wait_drive(1, "lz1");
      chk("lz_idx1", 32'(seg), 32'(7'b1111001));
      wait_drive(0, "lz0");
      chk("lz_idx0", 32'(seg), 32'(7'b1111110));
      cycles(N * P);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
